// File: rtl/dwconv_seq_ctrl_if.sv
// dwconv_seq_ctrl_if: control/handshake bundle between the depthwise sequencer and its neighbours
interface dwconv_seq_ctrl_if;
    logic       start;
    logic       abort;
    logic       src_valid;
    logic       ds_ready;
    logic       src_ready;
    logic       en;
    logic [4:0] cnt;
    logic [3:0] pos;
    logic       buf_valid;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, src_valid, ds_ready,
        input  src_ready, en, cnt, pos, buf_valid, busy, done
    );

    modport slave (
        input  start, abort, src_valid, ds_ready,
        output src_ready, en, cnt, pos, buf_valid, busy, done
    );
endinterface

// File: rtl/dwconv_seq_ctrl.sv
// dwconv_seq_ctrl: walks channels (inner) and kernel positions (outer) for the depthwise output bank
module dwconv_seq_ctrl #(
    parameter int N_CH  = 32,
    parameter int N_POS = 9
) (
    input  logic               clk,
    input  logic               rst,
    dwconv_seq_ctrl_if.slave   bus
);
    localparam logic [4:0] CNT_LAST = 5'(N_CH - 1);
    localparam logic [3:0] POS_LAST = 4'(N_POS - 1);

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, WAIT, DONE} state_t;

    state_t     state;
    logic [4:0] cnt;
    logic [3:0] pos;
    logic       buf_valid;
    logic       done;
    logic       en;

    assign en            = (state == RUN) && bus.src_valid;
    assign bus.src_ready = (state == RUN);
    assign bus.en        = en;
    assign bus.cnt       = cnt;
    assign bus.pos       = pos;
    assign bus.buf_valid = buf_valid;
    assign bus.done      = done;
    assign bus.busy      = (state != IDLE);

    // Sequencer: one write per accepted sample, one flush cycle for bank latency, then hand-off wait
    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            state     <= IDLE;
            cnt       <= '0;
            pos       <= '0;
            buf_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            buf_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state <= RUN;
                    cnt   <= '0;
                    pos   <= '0;
                end
                RUN: if (en) begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= FLUSH;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                FLUSH: begin
                    state     <= WAIT;
                    buf_valid <= 1'b1;
                end
                WAIT: if (bus.ds_ready) begin
                    if (pos == POS_LAST) begin
                        pos   <= '0;
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        pos   <= pos + 4'd1;
                        state <= RUN;
                    end
                end else begin
                    buf_valid <= 1'b1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dwconv_seq_ctrl.sv
// tb_dwconv_seq_ctrl: randomized bench against a write-progress reference model
module tb_dwconv_seq_ctrl;
    localparam int NC = 32;
    localparam int NP = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dwconv_seq_ctrl_if bus();
    dwconv_seq_ctrl #(.N_CH(NC), .N_POS(NP)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Model: writes completed this frame, cycles since the last write of a position (0 run, 1 flush, 2 wait)
    int m_k   = 0;
    int m_gap = 0;
    bit m_act = 0;
    bit m_fin = 0;
    bit last_en, last_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outs();
        bit rdy;
        int p;
        rdy = m_act && !m_fin && m_gap == 0;
        p   = m_fin ? 0 : (m_gap != 0 ? (m_k - 1) / NC : m_k / NC);
        chk("src_ready", bus.src_ready, rdy);
        chk("en", bus.en, rdy && bus.src_valid);
        chk("cnt", bus.cnt, m_fin ? 0 : m_k % NC);
        chk("pos", bus.pos, p);
        chk("buf_valid", bus.buf_valid, m_act && !m_fin && m_gap == 2);
        chk("busy", bus.busy, m_act);
        chk("done", bus.done, m_fin);
        last_en   = bus.en;
        last_done = bus.done;
    endtask

    task automatic model_edge(input bit st, input bit ab, input bit sv, input bit dr, input bit r);
        if (r || ab) begin
            m_act = 0; m_fin = 0; m_k = 0; m_gap = 0;
        end else if (m_fin) begin
            m_fin = 0; m_act = 0; m_k = 0;
        end else if (!m_act) begin
            if (st) begin m_act = 1; m_k = 0; m_gap = 0; end
        end else if (m_gap == 0) begin
            if (sv) begin
                m_k++;
                if (m_k % NC == 0) m_gap = 1;
            end
        end else if (m_gap == 1) begin
            m_gap = 2;
        end else if (dr) begin
            m_gap = 0;
            if (m_k == NC * NP) begin m_fin = 1; m_k = 0; end
        end
    endtask

    task automatic cyc(input bit st, input bit ab, input bit sv, input bit dr, input bit r);
        bus.start = st; bus.abort = ab; bus.src_valid = sv; bus.ds_ready = dr; rst = r;
        @(negedge clk);
        check_outs();
        @(posedge clk);
        model_edge(st, ab, sv, dr, r);
        #1;
    endtask

    initial begin
        int n, ens, dones;
        bus.start = 0; bus.abort = 0; bus.src_valid = 0; bus.ds_ready = 0; rst = 1;
        @(posedge clk); #1;
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 1, 0);
        // Unstalled frame: start accepted right after reset, fixed length and write count
        cyc(1, 0, 1, 1, 0);
        n = 0; ens = 0;
        while (n < 400) begin
            cyc(0, 0, 1, 1, 0);
            n++;
            ens += int'(last_en);
            if (last_done) break;
        end
        chk("frame_cycles", n, 307);
        chk("frame_writes", ens, 288);
        cyc(0, 0, 1, 1, 0);
        chk("idle_after_done", bus.busy, 0);
        // Abort at pos 5, cnt 17 then restart from zero
        cyc(1, 0, 1, 1, 0);
        n = 0;
        while (!(m_k == 5 * NC + 17 && m_gap == 0) && n < 400) begin
            cyc(0, 0, 1, 1, 0);
            n++;
        end
        chk("abort_reached", bus.cnt, 17);
        cyc(0, 1, 1, 1, 0);
        chk("abort_cnt", bus.cnt, 0);
        chk("abort_pos", bus.pos, 0);
        cyc(1, 1, 1, 1, 0);
        chk("abort_beats_start", bus.busy, 0);
        // Randomized traffic: stalls, back-pressure, stray starts, aborts and resets
        dones = 0;
        for (int i = 0; i < 20000; i++) begin
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 399) == 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 799) == 0);
            dones += int'(last_done);
        end
        chk("random_frames_seen", dones > 3, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
